// File: rtl/insn_fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch front end.
// Widths alias the core's instruction address and instruction datapaths.
package insn_fetch_unit_pkg;

  localparam int InsnAddrPath = 10;
  localparam int InsnPath     = 32;

  localparam int IFU_ADDR_WIDTH = InsnAddrPath;
  localparam int IFU_INSN_WIDTH = InsnPath;

  localparam logic [InsnPath-1:0] NOP = '0;

  typedef enum logic {
    FETCH_RUN,
    FETCH_DRAIN
  } fetch_state_t;

endpackage

// File: rtl/insn_fetch_unit_fifo.sv
// Synchronous FIFO with clear and occupancy count; DEPTH must be a power of two.
// Pushes into a full FIFO are dropped unless a pop frees a slot in the same cycle.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  input  logic                         clear,
  output logic [WIDTH-1:0]             head,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (occupancy == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && ((occupancy != CW'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      occupancy <= occupancy + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/insn_fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues in-order requests to a
// variable-latency IMem and buffers returned instructions for the decode stage.
module insn_fetch_unit
  import insn_fetch_unit_pkg::*;
#(
  parameter int                    ADDR_WIDTH = insn_fetch_unit_pkg::IFU_ADDR_WIDTH,
  parameter int                    INSN_WIDTH = insn_fetch_unit_pkg::IFU_INSN_WIDTH,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  reqValid,
  output logic [ADDR_WIDTH-1:0] reqAddr,
  input  logic                  reqReady,
  input  logic                  rspValid,
  input  logic [INSN_WIDTH-1:0] rspInsn,
  output logic                  insnValid,
  output logic [INSN_WIDTH-1:0] insn,
  output logic [ADDR_WIDTH-1:0] insnAddr,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] redirectAddr
);

  localparam int CW  = $clog2(DEPTH + 1);
  localparam int CW1 = CW + 1;
  localparam int QW  = ADDR_WIDTH + INSN_WIDTH;

  fetch_state_t          state;
  fetch_state_t          state_next;
  logic [ADDR_WIDTH-1:0] pc;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         drop_cnt;
  logic [CW-1:0]         occupancy;
  logic [CW-1:0]         flush_drop;
  logic [QW-1:0]         q_head;
  logic [ADDR_WIDTH-1:0] rsp_addr;
  logic                  q_empty;
  logic                  credit_ok;
  logic                  issue;
  logic                  rsp_fire;
  logic                  push;
  logic                  pop;

  // Registered occupancy makes credit freed by a pop visible only next cycle.
  assign credit_ok  = ({1'b0, occupancy} + {1'b0, outstanding}) < CW1'(DEPTH);
  assign rsp_fire   = rspValid && (outstanding != '0);
  assign flush_drop = outstanding - CW'(rsp_fire);
  assign reqValid   = rst && (state == FETCH_RUN) && !flush && credit_ok;
  assign reqAddr    = pc;
  assign issue      = reqValid && reqReady;

  // In RUN every outstanding request belongs to the current stream, so the
  // oldest one was issued exactly `outstanding` addresses before pc.
  assign rsp_addr = pc - ADDR_WIDTH'(outstanding);
  assign push     = rsp_fire && (state == FETCH_RUN) && !flush;
  assign pop      = !q_empty && !stall && !flush;

  fetch_fifo #(
    .WIDTH(QW),
    .DEPTH(DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({rsp_addr, rspInsn}),
    .pop       (pop),
    .clear     (flush),
    .head      (q_head),
    .empty     (q_empty),
    .occupancy (occupancy)
  );

  assign insnValid = !q_empty;
  assign insn      = insnValid ? q_head[INSN_WIDTH-1:0] : INSN_WIDTH'(NOP);
  assign insnAddr  = insnValid ? q_head[QW-1:INSN_WIDTH] : '0;

  always_ff @(posedge clk) begin
    if (!rst) state <= FETCH_RUN;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = (flush_drop != '0) ? FETCH_DRAIN : FETCH_RUN;
    end else if (state == FETCH_DRAIN) begin
      if ((drop_cnt == '0) || (rsp_fire && (drop_cnt == CW'(1)))) state_next = FETCH_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc          <= RESET_ADDR;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (flush) begin
      pc          <= redirectAddr;
      outstanding <= flush_drop;
      drop_cnt    <= flush_drop;
    end else begin
      if (issue) pc <= pc + ADDR_WIDTH'(1);
      outstanding <= outstanding + CW'(issue) - CW'(rsp_fire);
      if ((state == FETCH_DRAIN) && rsp_fire && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
    end
  end

  assert property (@(posedge clk) disable iff (!rst) !(rspValid && (outstanding == '0)));

endmodule

// File: tb/tb_insn_fetch_unit.sv
// Bench for insn_fetch_unit: a variable-latency IMem model with random backpressure,
// checked every cycle against a queue-based reference of the fetch stream.
`timescale 1ns/1ps
module tb_insn_fetch_unit;

  localparam int AW    = 10;
  localparam int IW    = 32;
  localparam int DEPTH = 4;
  localparam logic [AW-1:0] RESET_ADDR = '0;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          reqValid;
  logic [AW-1:0] reqAddr;
  logic          reqReady = 1'b0;
  logic          rspValid = 1'b0;
  logic [IW-1:0] rspInsn = '0;
  logic          insnValid;
  logic [IW-1:0] insn;
  logic [AW-1:0] insnAddr;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic [AW-1:0] redirectAddr = '0;

  always #5 clk = ~clk;

  insn_fetch_unit #(
    .ADDR_WIDTH(AW),
    .INSN_WIDTH(IW),
    .DEPTH(DEPTH),
    .RESET_ADDR(RESET_ADDR)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .reqValid     (reqValid),
    .reqAddr      (reqAddr),
    .reqReady     (reqReady),
    .rspValid     (rspValid),
    .rspInsn      (rspInsn),
    .insnValid    (insnValid),
    .insn         (insn),
    .insnAddr     (insnAddr),
    .stall        (stall),
    .flush        (flush),
    .redirectAddr (redirectAddr)
  );

  // One in-flight IMem request: address actually requested, address the
  // reference expects, cycle its response is due, and whether a flush killed it.
  typedef struct {
    int act_addr;
    int exp_addr;
    int due;
    bit killed;
  } pend_t;

  pend_t         pending[$];
  int            rq[$];
  logic [IW-1:0] memw [1024];
  int            model_pc;
  int            cyc;
  int            lat_min;
  int            lat_max;
  int            last_due;
  int            n_cmp;
  int            n_err;
  int            prev_del;
  bit            rsp_now;
  bit            seen_wrap;
  bit            seen_bad;
  bit            found;

  function automatic bit has_killed();
    foreach (pending[i]) if (pending[i].killed) return 1'b1;
    return 1'b0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("[TB] FAIL %s @cycle %0d: observed %h expected %h", tag, cyc, obs, expv);
    end
  endtask

  task automatic beginCycle();
    @(negedge clk);
    rsp_now  = (pending.size() > 0) && (pending[0].due == cyc);
    rspValid = rsp_now;
    rspInsn  = rsp_now ? memw[pending[0].act_addr] : $urandom;
  endtask

  task automatic applyStimulus(input bit ready, input bit stl, input bit fl, input logic [AW-1:0] redir);
    rst          = 1'b1;
    reqReady     = ready;
    stall        = stl;
    flush        = fl;
    redirectAddr = redir;
  endtask

  // Compare outputs against the reference, then advance memory and reference past the edge.
  task automatic advanceCycle();
    bit    exp_rv;
    int    due;
    pend_t e;
    #1;
    exp_rv = !flush && !has_killed() && ((rq.size() + pending.size()) < DEPTH);
    checkOutput("reqValid", 32'(reqValid), 32'(exp_rv));
    if (exp_rv) checkOutput("reqAddr", 32'(reqAddr), 32'(model_pc));
    checkOutput("insnValid", 32'(insnValid), 32'(rq.size() > 0));
    checkOutput("insnAddr", 32'(insnAddr), (rq.size() > 0) ? 32'(rq[0]) : 32'd0);
    checkOutput("insn", insn, (rq.size() > 0) ? memw[rq[0]] : 32'd0);

    if (insnValid && !stall && !flush) begin
      if ((int'(insnAddr) == 0) && (prev_del == 'h3FF)) seen_wrap = 1'b1;
      if ((int'(insnAddr) >= 'h40) && (int'(insnAddr) < 'h80)) seen_bad = 1'b1;
      prev_del = int'(insnAddr);
    end

    if (flush) begin
      rq.delete();
      if (rsp_now) void'(pending.pop_front());
      foreach (pending[i]) pending[i].killed = 1'b1;
      model_pc = int'(redirectAddr);
    end else begin
      if ((rq.size() > 0) && !stall) void'(rq.pop_front());
      if (rsp_now) begin
        e = pending.pop_front();
        if (!e.killed) rq.push_back(e.exp_addr);
      end
      if (exp_rv && reqReady) model_pc = (model_pc + 1) % 1024;
    end

    if (reqValid && reqReady) begin
      due = cyc + int'($urandom_range(lat_max, lat_min));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pending.push_back('{act_addr: int'(reqAddr), exp_addr: (exp_rv ? model_pc - 1 : model_pc) & 'h3FF,
                          due: due, killed: 1'b0});
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic cycle(input bit ready, input bit stl, input bit fl, input logic [AW-1:0] redir);
    beginCycle();
    applyStimulus(ready, stl, fl, redir);
    advanceCycle();
  endtask

  task automatic resetCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b0; rspValid = 1'b0; reqReady = 1'b1; stall = 1'b0; flush = 1'b0;
      #1;
      checkOutput("reqValid_rst", 32'(reqValid), 32'd0);
      if (i > 0) begin
        checkOutput("insnValid_rst", 32'(insnValid), 32'd0);
        checkOutput("insn_rst", insn, 32'd0);
        checkOutput("insnAddr_rst", 32'(insnAddr), 32'd0);
      end
      @(posedge clk);
      cyc++;
    end
    pending.delete();
    rq.delete();
    model_pc = int'(RESET_ADDR);
    last_due = cyc;
  endtask

  // Run with L=3 until three requests are in flight and one is returning, then flush.
  task automatic flushWithThreeOutstanding(input logic [AW-1:0] redir);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      beginCycle();
      if ((pending.size() == 3) && rsp_now) begin
        applyStimulus(1'b1, 1'b0, 1'b1, redir);
        found = 1'b1;
      end else begin
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
      end
      advanceCycle();
    end
    checkOutput("flush_setup", 32'(found), 32'd1);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    foreach (memw[i]) memw[i] = $urandom;
    n_cmp = 0; n_err = 0; cyc = 0; last_due = 0; prev_del = -1;
    seen_wrap = 1'b0; seen_bad = 1'b0; model_pc = 0;
    lat_min = 1; lat_max = 1;

    resetCycles(3);

    // Streaming with single-cycle latency, then a long stall against a full pipe.
    repeat (12) cycle(1'b1, 1'b0, 1'b0, '0);
    repeat (6)  cycle(1'b1, 1'b1, 1'b0, '0);
    repeat (10) cycle(1'b1, 1'b0, 1'b0, '0);

    lat_min = 1; lat_max = 4;
    repeat (80) cycle($urandom_range(99) < 70, $urandom_range(99) < 30, 1'b0, '0);

    // Flush while three requests are outstanding and one returns that cycle.
    resetCycles(2);
    lat_min = 3; lat_max = 3;
    flushWithThreeOutstanding(10'h040);
    repeat (15) cycle(1'b1, 1'b0, 1'b0, '0);

    // Second redirect while still draining the first.
    resetCycles(2);
    flushWithThreeOutstanding(10'h040);
    seen_bad = 1'b0;
    cycle(1'b1, 1'b0, 1'b1, 10'h080);
    repeat (20) cycle(1'b1, 1'b0, 1'b0, '0);
    checkOutput("no_0x40_after_redirect", 32'(seen_bad), 32'd0);

    // Address wrap with random latency and backpressure.
    lat_min = 1; lat_max = 4;
    cycle(1'b1, 1'b0, 1'b1, 10'h3FE);
    repeat (60) cycle($urandom_range(99) < 70, 1'b0, 1'b0, '0);
    checkOutput("wrap_3FF_to_000", 32'(seen_wrap), 32'd1);

    // Reset with work in flight and a stalled queue.
    lat_min = 3; lat_max = 3;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if ((pending.size() >= 2) && (rq.size() >= 1)) found = 1'b1;
      else cycle(1'b1, 1'b1, 1'b0, '0);
    end
    checkOutput("midop_setup", 32'(found), 32'd1);
    resetCycles(2);
    lat_min = 1; lat_max = 1;
    repeat (10) cycle(1'b1, 1'b0, 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
